muldiv_seq: RTL
===============

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have input clk, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have input rst_n, 1 bit: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have input start, 1 bit: EX-stage instruction valid this cycle.
REQ-005 SHALL have input alu_op, 2 bits: main-decoder ALU op; only 2'b10 (R-type) is acted on.
REQ-006 SHALL have input func, 6 bits: R-type function field.
REQ-007 SHALL have inputs op_a and op_b, WIDTH bits each: rs and rt operand values.
REQ-008 SHALL have output busy, 1 bit: an iterative operation is in flight.
REQ-009 SHALL have output stall, 1 bit: the pipeline must hold the EX instruction this cycle.
REQ-010 SHALL have output done, 1 bit: one-cycle pulse; HI/LO hold a new result.
REQ-011 SHALL have output div_by_zero, 1 bit: qualifies done; divisor was zero.
REQ-012 SHALL have outputs hi and lo, WIDTH bits each: architectural HI/LO registers.
REQ-013 SHALL have output rd_data, WIDTH bits: MFHI/MFLO result for write-back.

Function
REQ-014 SHALL decode, when alu_op==2'b10: MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011; all other func values are ignored.
REQ-015 SHALL implement states IDLE, MUL, DIV, FIX, DONE; busy=1 in MUL, DIV and FIX.
REQ-016 SHALL accept a mult/div in IDLE or DONE when start=1 (cycle 0), latch operands, and enter MUL or DIV at the cycle-0 edge.
REQ-017 SHALL iterate one bit per cycle (radix-2 shift-add / restoring divide, unsigned magnitudes) for exactly 32 cycles (cycles 1..32), then FIX for 1 cycle (cycle 33), applying sign correction for MULT/DIV.
REQ-018 SHALL update hi/lo at the FIX->DONE edge; done=1 in cycle 34 only; DONE returns to IDLE unless a new accept occurs.
REQ-019 SHALL produce for MULT/MULTU {hi,lo} = the 64-bit signed/unsigned product.
REQ-020 SHALL produce for DIV/DIVU lo=quotient and hi=remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-021 SHALL, for DIV/DIVU with op_b==0, skip iteration: go from IDLE to DONE in one cycle, set hi=op_a and lo=0xFFFFFFFF, and raise done and div_by_zero in cycle 1.
REQ-022 SHALL drive stall combinationally = start & alu_op==2'b10 & (any REQ-014 func) & busy; start while busy is ignored and is not queued.
REQ-023 SHALL, for MTHI/MTLO when not busy, write op_a to hi/lo at the cycle-0 edge without changing state.
REQ-024 SHALL drive rd_data = hi for MFHI and lo for MFLO when not busy, else 0; in DONE it reflects the new result.

Reset
REQ-025 SHALL, when rst_n=0, immediately force state=IDLE, hi=lo=0, busy=stall-source=done=div_by_zero=0, and clear all iteration registers, including mid-operation; the first accept is possible on the first edge with rst_n=1.

Configuration
REQ-026 SHALL, with macro MULDIV_DIV_EN defined, implement DIV/DIVU as specified; without it, DIV/DIVU are ignored (no state change, no stall, hi/lo unchanged), the DIV state and divide datapath are absent, and div_by_zero is tied 0.

Verification
REQ-027 SHALL cover: MULT op_a=0xFFFFFFFF, op_b=2 -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-028 SHALL cover: MULTU op_a=0xFFFFFFFF, op_b=2 -> hi=0x00000001, lo=0xFFFFFFFE, busy=1 in cycles 1..33.
REQ-029 SHALL cover: DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> cycle-1 done=1, div_by_zero=1, hi=7, lo=0xFFFFFFFF.
REQ-030 SHALL cover: MFLO held with start=1 from cycle 5 after a MULT -> stall=1 in cycles 5..33, stall=0 and rd_data=new lo in cycle 34.
REQ-031 SHALL cover: rst_n pulsed low in cycle 10 of a MULT -> busy=0 and hi=lo=0 before the next edge, no done pulse, and a new MULT completes normally.
REQ-032 SHALL cover: MTHI op_a=0x12345678, then MFHI -> rd_data=0x12345678; build without MULDIV_DIV_EN, DIV -> busy stays 0 and hi/lo unchanged.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative HI/LO multiply/divide unit, one bit per cycle, 32 iterations plus a sign-fix cycle.
// Define MULDIV_DIV_EN to build DIV/DIVU; without it divides are ignored and div_by_zero is tied low.
module muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef MULDIV_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_FIX, S_DONE} state_t;
`endif

  state_t state, state_nxt;

  logic op_mult, op_multu, op_div, op_divu;
  logic op_mfhi, op_mthi, op_mflo, op_mtlo;
  logic any_op, sgn_op, acc_mul, acc_div, div_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc, mul_nxt, prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   dvsr;
  logic [CW-1:0]      cnt;
  logic               neg_q;

  // Instruction decode and operand magnitudes
  always_comb begin
    op_mult  = start && (alu_op == 2'b10) && (func == F_MULT);
    op_multu = start && (alu_op == 2'b10) && (func == F_MULTU);
    op_mfhi  = start && (alu_op == 2'b10) && (func == F_MFHI);
    op_mthi  = start && (alu_op == 2'b10) && (func == F_MTHI);
    op_mflo  = start && (alu_op == 2'b10) && (func == F_MFLO);
    op_mtlo  = start && (alu_op == 2'b10) && (func == F_MTLO);
`ifdef MULDIV_DIV_EN
    op_div   = start && (alu_op == 2'b10) && (func == F_DIV);
    op_divu  = start && (alu_op == 2'b10) && (func == F_DIVU);
`else
    op_div   = 1'b0;
    op_divu  = 1'b0;
`endif
    any_op   = op_mult || op_multu || op_div || op_divu ||
               op_mfhi || op_mthi || op_mflo || op_mtlo;
    sgn_op   = op_mult || op_div;
    acc_mul  = (op_mult || op_multu) && !busy;
    acc_div  = (op_div || op_divu) && !busy;
    div_zero = acc_div && (op_b == '0);
    mag_a    = (sgn_op && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b    = (sgn_op && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  assign stall = any_op && busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (acc_mul) state_nxt = S_MUL;
`ifdef MULDIV_DIV_EN
        else if (acc_div) state_nxt = div_zero ? S_DONE : S_DIV;
`endif
      end
      S_MUL: if (cnt == LAST) state_nxt = S_FIX;
`ifdef MULDIV_DIV_EN
      S_DIV: if (cnt == LAST) state_nxt = S_FIX;
`endif
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_MUL, S_FIX: busy = 1'b1;
`ifdef MULDIV_DIV_EN
      S_DIV:        busy = 1'b1;
`endif
      S_DONE:       done = 1'b1;
      default: ;
    endcase
  end

  // Move-from path; DONE is not busy so the fresh result is visible there
  always_comb begin
    rd_data = '0;
    if (!busy) begin
      if (op_mfhi)      rd_data = hi;
      else if (op_mflo) rd_data = lo;
    end
  end

  // Shift-add: acc = {partial product, remaining multiplier bits}
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? dvsr : '0)};
    mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    prod_fix = neg_q ? -acc : acc;
  end

`ifdef MULDIV_DIV_EN
  logic             neg_r, is_div, dbz;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Restoring divide: acc = {partial remainder, dividend bits becoming quotient}
  always_comb begin
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
    q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign div_by_zero = dbz;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      dvsr  <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MULDIV_DIV_EN
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
`endif
    end else begin
`ifdef MULDIV_DIV_EN
      dbz <= div_zero;
`endif
      if (acc_mul || (acc_div && !div_zero)) begin
        acc   <= {{WIDTH{1'b0}}, mag_a};
        dvsr  <= mag_b;
        cnt   <= '0;
        neg_q <= sgn_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
        neg_r  <= sgn_op && op_a[WIDTH-1];
        is_div <= acc_div;
`endif
      end else if (state == S_MUL) begin
        acc <= mul_nxt;
        cnt <= cnt + CW'(1);
      end
`ifdef MULDIV_DIV_EN
      else if (state == S_DIV) begin
        acc <= div_nxt;
        cnt <= cnt + CW'(1);
      end
`endif
      if (state == S_FIX) begin
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          hi <= r_fix;
          lo <= q_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
`else
        {hi, lo} <= prod_fix;
`endif
      end
`ifdef MULDIV_DIV_EN
      if (div_zero) begin
        hi <= op_a;
        lo <= '1;
      end
`endif
      if (op_mthi && !busy) hi <= op_a;
      if (op_mtlo && !busy) lo <= op_a;
    end
  end

endmodule
